// File: rtl/mprj_io_pkg.sv
// Shared definitions for the user-project GPIO serial configuration loader:
// loader state encoding, configuration-word layout and sizing helpers.
package mprj_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_D,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } ser_state_t;

    localparam int CFG_BITS_DEFAULT = 13;

    // Bit offsets of the per-pad configuration word.
    localparam int CFG_MGMT_EN  = 0;
    localparam int CFG_OUTENB   = 1;
    localparam int CFG_HLDH     = 2;
    localparam int CFG_INP_DIS  = 3;
    localparam int CFG_MOD_SEL  = 4;
    localparam int CFG_ANLG_EN  = 5;
    localparam int CFG_ANLG_SEL = 6;
    localparam int CFG_ANLG_POL = 7;
    localparam int CFG_SLOW     = 8;
    localparam int CFG_TRIP     = 9;
    localparam int CFG_DM       = 10;
    localparam int CFG_DM_W     = 3;

    typedef struct packed {
        logic [CFG_DM_W-1:0] dm;
        logic                trip;
        logic                slow;
        logic                anlg_pol;
        logic                anlg_sel;
        logic                anlg_en;
        logic                mod_sel;
        logic                inp_dis;
        logic                hldh;
        logic                outenb;
        logic                mgmt_en;
    } pad_cfg_t;

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mprj_io_ser_tick.sv
// Half-period timer for the serial chain: tick marks the last core-clock
// cycle of every CLK_DIV-cycle interval; clear holds it at the first cycle.
module mprj_io_ser_tick
    import mprj_io_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = min1_clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mprj_io_serial_loader.sv
// Reads one configuration word per pad and shifts them, highest pad first and
// MSB first, through the GPIO control chain, then pulses the chain load strobe.
module mprj_io_serial_loader
    import mprj_io_pkg::*;
#(
    parameter int PADS     = 38,
    parameter int CFG_BITS = CFG_BITS_DEFAULT,
    parameter int CLK_DIV  = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    output logic [min1_clog2(PADS)-1:0]  cfg_addr,
    input  logic [CFG_BITS-1:0]          cfg_data,
    output logic                         busy,
    output logic                         done,
    output logic                         serial_clock,
    output logic                         serial_data_out,
    output logic                         serial_load,
    output logic                         serial_resetn
);

    localparam int            AW       = min1_clog2(PADS);
    localparam int            BW       = min1_clog2(CFG_BITS);
    localparam logic [AW-1:0] LAST_PAD = AW'(PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);

    ser_state_t          state;
    logic [AW-1:0]       pad_idx;
    logic [BW-1:0]       bit_cnt;
    logic [CFG_BITS-1:0] shreg;
    logic [CFG_BITS-1:0] shreg_next;
    logic                tick;
    logic                tick_clear;

    // Rotate rather than shift: bits wrapping into the LSB are never sent.
    assign shreg_next = CFG_BITS'({shreg, shreg} >> (CFG_BITS - 1));

    assign cfg_addr = pad_idx;

    always_comb begin
        tick_clear = !(state inside {S_SHIFT_LO, S_SHIFT_HI, S_LOAD});
    end

    mprj_io_ser_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clear  (tick_clear),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            serial_resetn <= 1'b0;
        end else begin
            serial_resetn <= 1'b1;
        end
    end

    // Outputs are set on the transition into a state so they are valid for
    // the whole time the state is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            pad_idx         <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pad_idx <= LAST_PAD;
                        busy    <= 1'b1;
                        state   <= S_FETCH_A;
                    end
                end
                S_FETCH_A: begin
                    state <= S_FETCH_D;
                end
                S_FETCH_D: begin
                    shreg           <= cfg_data;
                    bit_cnt         <= LAST_BIT;
                    serial_data_out <= cfg_data[CFG_BITS-1];
                    state           <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    if (tick) begin
                        serial_clock <= 1'b1;
                        state        <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (tick) begin
                        serial_clock <= 1'b0;
                        shreg        <= shreg_next;
                        if (bit_cnt != '0) begin
                            bit_cnt         <= bit_cnt - BW'(1);
                            serial_data_out <= shreg_next[CFG_BITS-1];
                            state           <= S_SHIFT_LO;
                        end else if (pad_idx != '0) begin
                            pad_idx <= pad_idx - AW'(1);
                            state   <= S_FETCH_A;
                        end else begin
                            serial_load <= 1'b1;
                            state       <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (tick) begin
                        serial_load <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Self-checking bench: four loader configurations driven in turn, each
// observed by a shift-register model of the GPIO control chain.
module tb_mprj_io_serial_loader;

    localparam int NI  = 4;
    localparam int CHW = 38 * 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] resetn, start;
    logic [NI-1:0] busy, done, sclk, sdat, sload, srstn;
    logic [0:0]    addr0, addr1, addr2;
    logic [5:0]    addr3;
    logic [12:0]   rd0, rd1, rd3;
    logic [0:0]    rd2;
    logic [12:0]   mem [NI][38];

    int checks = 0;
    int errors = 0;

    // Synchronous-read configuration memories, one per instance.
    always @(posedge clk) begin
        rd0 <= mem[0][addr0];
        rd1 <= mem[1][addr1];
        rd2 <= mem[2][addr2][0:0];
        rd3 <= mem[3][addr3];
    end

    mprj_io_serial_loader #(.PADS(2), .CFG_BITS(13), .CLK_DIV(1)) u_a (
        .clk(clk), .resetn(resetn[0]), .start(start[0]), .cfg_addr(addr0), .cfg_data(rd0),
        .busy(busy[0]), .done(done[0]), .serial_clock(sclk[0]), .serial_data_out(sdat[0]),
        .serial_load(sload[0]), .serial_resetn(srstn[0]));

    mprj_io_serial_loader #(.PADS(2), .CFG_BITS(13), .CLK_DIV(3)) u_b (
        .clk(clk), .resetn(resetn[1]), .start(start[1]), .cfg_addr(addr1), .cfg_data(rd1),
        .busy(busy[1]), .done(done[1]), .serial_clock(sclk[1]), .serial_data_out(sdat[1]),
        .serial_load(sload[1]), .serial_resetn(srstn[1]));

    mprj_io_serial_loader #(.PADS(1), .CFG_BITS(1), .CLK_DIV(1)) u_c (
        .clk(clk), .resetn(resetn[2]), .start(start[2]), .cfg_addr(addr2), .cfg_data(rd2),
        .busy(busy[2]), .done(done[2]), .serial_clock(sclk[2]), .serial_data_out(sdat[2]),
        .serial_load(sload[2]), .serial_resetn(srstn[2]));

    mprj_io_serial_loader #(.PADS(38), .CFG_BITS(13), .CLK_DIV(2)) u_d (
        .clk(clk), .resetn(resetn[3]), .start(start[3]), .cfg_addr(addr3), .cfg_data(rd3),
        .busy(busy[3]), .done(done[3]), .serial_clock(sclk[3]), .serial_data_out(sdat[3]),
        .serial_load(sload[3]), .serial_resetn(srstn[3]));

    // Observation state, owned by the monitor; the stimulus resets it via req/ack.
    logic [NI-1:0]  clr_req = '0;
    logic [NI-1:0]  clr_ack = '0;
    logic [NI-1:0]  sclk_q = '0, sdat_q = '0, sload_q = '0;
    logic [CHW-1:0] chain [NI];
    logic [CHW-1:0] latched [NI];
    int unsigned busy_cyc [NI], done_cnt [NI], done_at [NI], done_nobusy [NI];
    int unsigned sc_edges [NI], sc_at_load [NI], load_pulses [NI], load_cyc [NI];
    int unsigned overlap [NI], dviol [NI];
    int unsigned hi_run [NI], hi_min [NI], hi_max [NI], lo_run [NI], lo_min [NI];

    initial for (int i = 0; i < NI; i++) chain[i] = '0;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (clr_req[i] !== clr_ack[i]) begin
                clr_ack[i] = clr_req[i];
                busy_cyc[i] = 0; done_cnt[i] = 0; done_at[i] = 0; done_nobusy[i] = 0;
                sc_edges[i] = 0; sc_at_load[i] = 0; load_pulses[i] = 0; load_cyc[i] = 0;
                overlap[i] = 0; dviol[i] = 0; hi_run[i] = 0; hi_max[i] = 0; lo_run[i] = 0;
                hi_min[i] = '1; lo_min[i] = '1; latched[i] = '0;
            end
            if (busy[i]) busy_cyc[i]++;
            if (done[i]) begin
                done_cnt[i]++;
                done_at[i] = busy_cyc[i];
                if (!busy[i]) done_nobusy[i]++;
            end
            if (sclk[i] && !sclk_q[i]) begin
                chain[i] = {chain[i][CHW-2:0], sdat[i]};
                sc_edges[i]++;
            end
            if (sclk[i] && (sdat[i] !== sdat_q[i])) dviol[i]++;
            if (sload[i]) begin
                load_cyc[i]++;
                if (!sload_q[i]) begin
                    load_pulses[i]++;
                    latched[i] = chain[i];
                    sc_at_load[i] = sc_edges[i];
                end
            end
            if (sload[i] && sclk[i]) overlap[i]++;
            if (sclk[i]) hi_run[i]++;
            else if (sclk_q[i]) begin
                if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
                if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
                hi_run[i] = 0;
            end
            if (busy[i] && !sclk[i]) lo_run[i]++;
            else if (lo_run[i] != 0) begin
                if (lo_run[i] < lo_min[i]) lo_min[i] = lo_run[i];
                lo_run[i] = 0;
            end
            sclk_q[i]  = sclk[i];
            sdat_q[i]  = sdat[i];
            sload_q[i] = sload[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input int i);
        clr_req[i] = ~clr_req[i];
        @(negedge clk);
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!done[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
    endtask

    // Pad p's block occupies chain cells p*cb .. p*cb+cb-1, LSB in the lowest cell.
    task automatic check_words(input int i, input int pads, input int cb);
        logic [12:0] w;
        for (int p = 0; p < pads; p++) begin
            w = '0;
            for (int b = 0; b < cb; b++) w[b] = latched[i][p*cb + b];
            check($sformatf("word%0d_pad%0d", i, p), 32'(w),
                  32'(mem[i][p] & 13'((1 << cb) - 1)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = '0;
        start  = '0;
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < 38; p++) mem[i][p] = 13'($urandom);
        mem[0][0] = 13'h1803;
        mem[0][1] = 13'h0403;
        mem[2][0] = 13'h0001;

        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_sdat",  32'(sdat),  32'd0);
        check("rst_sload", 32'(sload), 32'd0);
        check("rst_srstn", 32'(srstn), 32'd0);
        check("rst_addr",  32'({addr3, addr2, addr1, addr0}), 32'd0);
        resetn = '1;
        check("srstn_hold", 32'(srstn), 32'd0);
        @(negedge clk);
        check("srstn_rise", 32'(srstn), 32'hF);

        // Basic load
        clear_stats(0);
        pulse_start(0);
        check("a_busy_rise", 32'(busy[0]), 32'd1);
        wait_done(0, 200);
        repeat (3) @(negedge clk);
        check("a_done_at",    done_at[0],     32'd58);
        check("a_busy_len",   busy_cyc[0],    32'd58);
        check("a_done_cnt",   done_cnt[0],    32'd1);
        check("a_done_busy",  done_nobusy[0], 32'd0);
        check("a_edges",      sc_edges[0],    32'd26);
        check("a_edge_load",  sc_at_load[0],  32'd26);
        check("a_load_pulse", load_pulses[0], 32'd1);
        check("a_load_len",   load_cyc[0],    32'd1);
        check("a_overlap",    overlap[0],     32'd0);
        check("a_dstable",    dviol[0],       32'd0);
        check("a_stream",     32'(latched[0][25:0]), 32'({13'h0403, 13'h1803}));
        check_words(0, 2, 13);

        // Start while busy, then start in the DONE cycle
        clear_stats(0);
        pulse_start(0);
        repeat (9) @(negedge clk);
        pulse_start(0);
        wait_done(0, 200);
        pulse_start(0);
        repeat (5) @(negedge clk);
        check("sb_done_at",  done_at[0],  32'd58);
        check("sb_busy_len", busy_cyc[0], 32'd58);
        check("sb_done_cnt", done_cnt[0], 32'd1);
        check("sd_idle",     32'(busy[0]), 32'd0);

        // Reset mid-shift
        clear_stats(0);
        pulse_start(0);
        repeat (19) @(negedge clk);
        check("mr_busy_pre", 32'(busy[0]), 32'd1);
        resetn[0] = 1'b0;
        #1;
        check("mr_outs", 32'({busy[0], done[0], sclk[0], sdat[0], sload[0], srstn[0], addr0}), 32'd0);
        @(negedge clk);
        resetn[0] = 1'b1;
        check("mr_srstn_hold", 32'(srstn[0]), 32'd0);
        @(negedge clk);
        check("mr_srstn_rise", 32'(srstn[0]), 32'd1);
        repeat (100) @(negedge clk);
        check("mr_outs_idle", 32'({busy[0], done[0], sclk[0], sdat[0], sload[0], addr0}), 32'd0);
        check("mr_no_load",   load_pulses[0], 32'd0);
        check("mr_no_done",   done_cnt[0],    32'd0);
        clear_stats(0);
        pulse_start(0);
        wait_done(0, 200);
        repeat (3) @(negedge clk);
        check("mr_reload_len",  busy_cyc[0],    32'd58);
        check("mr_reload_load", load_pulses[0], 32'd1);
        check_words(0, 2, 13);

        // Divider timing, CLK_DIV=3
        clear_stats(1);
        pulse_start(1);
        wait_done(1, 400);
        repeat (3) @(negedge clk);
        check("b_busy_len", busy_cyc[1], 32'd164);
        check("b_done_at",  done_at[1],  32'd164);
        check("b_hi_min",   hi_min[1],   32'd3);
        check("b_hi_max",   hi_max[1],   32'd3);
        check("b_lo_min",   lo_min[1],   32'd3);
        check("b_dstable",  dviol[1],    32'd0);
        check("b_overlap",  overlap[1],  32'd0);
        check("b_load_len", load_cyc[1], 32'd3);
        check("b_edges",    sc_edges[1], 32'd26);
        check_words(1, 2, 13);

        // Edge parameters: one pad, one bit
        clear_stats(2);
        pulse_start(2);
        wait_done(2, 50);
        repeat (3) @(negedge clk);
        check("c_busy_len",   busy_cyc[2],    32'd6);
        check("c_edges",      sc_edges[2],    32'd1);
        check("c_load_len",   load_cyc[2],    32'd1);
        check("c_load_pulse", load_pulses[2], 32'd1);
        check("c_bit",        32'(latched[2][0]), 32'd1);
        check_words(2, 1, 1);

        // Randomized 38-pad load
        clear_stats(3);
        pulse_start(3);
        wait_done(3, 3000);
        repeat (3) @(negedge clk);
        check("d_busy_len",   busy_cyc[3],    32'd2055);
        check("d_edges",      sc_edges[3],    32'd494);
        check("d_load_pulse", load_pulses[3], 32'd1);
        check("d_load_len",   load_cyc[3],    32'd2);
        check("d_overlap",    overlap[3],     32'd0);
        check("d_dstable",    dviol[3],       32'd0);
        check_words(3, 38, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mprj_io_serial_loader.md
# mprj_io_serial_loader

Serial configuration loader for the user-project GPIO control chain. It sits directly upstream of the pad array: it reads one configuration word per pad from the housekeeping register file and shifts those words through the daisy-chained GPIO control blocks. It then pulses a load strobe so every control block latches the word that drives its pad's `dm`, `oeb`, `inp_dis`, `ib_mode_sel`, `vtrip_sel`, `slow_sel`, `holdover` and analog controls.

## Interface
- `PADS`, default 38: number of pads in the chain; must be ≥1 (equals `MPRJ_IO_PADS`).
- `CFG_BITS`, default 13: bits per pad configuration word; must be ≥1.
- `CLK_DIV`, default 2: core-clock cycles per serial-clock half period; must be ≥1.

Ports:
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset. This is the only reset; the block uses one clock.
- `start` in 1: single-cycle request to begin a full chain load.
- `cfg_addr` out $clog2(PADS): pad index of the word being read.
- `cfg_data` in CFG_BITS: word for `cfg_addr`. Valid one cycle after `cfg_addr` changes (synchronous read).
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse on completion.
- `serial_clock` out 1: chain shift clock. Control blocks sample on its rising edge.
- `serial_data_out` out 1: chain data.
- `serial_load` out 1: chain latch strobe.
- `serial_resetn` out 1: chain reset, active low.

## Operation
States are IDLE, FETCH_A, FETCH_D, SHIFT_LO, SHIFT_HI, LOAD and DONE.

- **IDLE**
  - `start`=1 → FETCH_A with pad index = PADS-1.
  - `start` is ignored in every other state.
- **FETCH_A:** drive `cfg_addr` = pad index.
- **FETCH_D:** capture `cfg_data` into the shift register and set bit counter = CFG_BITS-1.
- **SHIFT_LO**
  - `serial_clock`=0 and `serial_data_out` = shift register MSB.
  - Stay for CLK_DIV cycles, then → SHIFT_HI.
- **SHIFT_HI**
  - `serial_clock`=1 for CLK_DIV cycles; the data bit is held stable throughout.
  - At exit, shift left by one bit.
  - If bit counter > 0: decrement it → SHIFT_LO.
  - Else if pad index > 0: decrement pad index → FETCH_A.
  - Else → LOAD.
- **LOAD:** `serial_clock`=0 and `serial_load`=1 for CLK_DIV cycles → DONE.
- **DONE:** `done`=1 for one cycle → IDLE.

Ordering rules:
- Pads are shifted from highest index to lowest. Within each word, bits go MSB first.
- After the full sequence, pad 0's block holds word 0.

## Timing
- Reset values: `busy`=0, `done`=0, `serial_clock`=0, `serial_data_out`=0, `serial_load`=0, `cfg_addr`=0, `serial_resetn`=0.
- `serial_resetn` is the registered version of `resetn`. It goes high on the first `clk` edge after `resetn` deasserts.
- `busy` rises in the cycle after `start` is sampled. It stays high through the DONE cycle inclusive, so `done` coincides with the last cycle of `busy`.
- Busy duration is PADS·(2 + 2·CLK_DIV·CFG_BITS) + CLK_DIV + 1 cycles. Example: PADS=2, CFG_BITS=13, CLK_DIV=1 gives 58 cycles.
- All serial outputs are registered, with no combinational path from inputs.
- `serial_data_out` changes only in the first SHIFT_LO cycle, never while `serial_clock`=1.
- `serial_load` never overlaps `serial_clock`=1.
- Reset asserted mid-load:
  - All outputs take their reset values immediately.
  - `serial_load` is never pulsed, so the chain keeps its previously latched configuration.
  - The state machine returns to IDLE.
- `start` asserted in the same cycle as DONE is ignored. A new load requires `start` while in IDLE.

## Structure
- Shared package `mprj_io_pkg`:
  - the state enum;
  - the `CFG_BITS` default;
  - bit-field offsets of the configuration word: mgmt_en 0, outenb 1, hldh 2, inp_dis 3, mod_sel 4, anlg_en 5, anlg_sel 6, anlg_pol 7, slow 8, trip 9, dm 10–12.
- One sub-module, `mprj_io_ser_tick`:
  - a CLK_DIV half-period counter with `clear` input and `tick` output;
  - it is reused to time SHIFT_LO, SHIFT_HI and LOAD.
- Everything else (shift register, bit and pad counters, state machine) lives in the top module.

## Test plan
- **Basic load.** PADS=2, CFG_BITS=13, CLK_DIV=1, memory {pad0=0x1803, pad1=0x0403}, pulse `start`.
  - Chain model captures 26 bits: 0x0403 MSB-first, then 0x1803.
  - `serial_load` rises once after the 26th rising edge.
  - `done` occurs at busy cycle 58.
- **Divider timing.** CLK_DIV=3.
  - Each `serial_clock` high and low phase lasts exactly 3 cycles.
  - `serial_data_out` is stable throughout each high phase.
  - Busy lasts 2·(2+78)+4 = 164 cycles.
- **Start while busy.** Pulse `start` again at busy cycle 10 → no restart; `done` still occurs at the original cycle.
- **Reset mid-shift.** Assert `resetn`=0 at busy cycle 20, then release and wait 100 cycles.
  - All outputs are 0; `serial_load` is never seen.
  - `serial_resetn` goes high 1 cycle after release.
  - A subsequent `start` performs a full, correct load.
- **Edge parameters.** PADS=1, CFG_BITS=1, CLK_DIV=1, word 0x1.
  - Exactly one serial clock pulse with data=1.
  - Load lasts 1 cycle; busy lasts 6 cycles.
- **Randomized memory.** PADS=38, CLK_DIV=2, random memory contents → the scoreboard chain model matches every pad word after `serial_load`.
